// File: rtl/maquina_senha.sv
`timescale 1ns/1ps
// Purpose: digit-by-digit code lock with error counting, timed lockout and a seven-segment display.
// Latency: every output is decoded from flops and updates at the clk edge that accepts a digit.
// Backpressure: none; digits are taken on insere rising edges, and edges seen in lockout are dropped.
module maquina_senha #(
    parameter int                 DIGITOS         = 6,
    parameter int                 MAX_ERROS       = 1,
    parameter int                 BLOQUEIO_CICLOS = 16,
    parameter logic [4*DIGITOS-1:0] SENHA         = 24'h590981
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             insere,
    input  logic [3:0]                       numero,
    input  logic                             grava,
    input  logic [4*DIGITOS-1:0]             nova_senha,
    output logic                             LED,
    output logic                             aberto,
    output logic                             bloqueado,
    output logic [$clog2(MAX_ERROS+2)-1:0]   erros,
    output logic                             A,
    output logic                             B,
    output logic                             C,
    output logic                             D,
    output logic                             E,
    output logic                             F,
    output logic                             G
);

    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam int TW = $clog2(BLOQUEIO_CICLOS + 1);
    localparam int EW = $clog2(MAX_ERROS + 2);

    localparam logic [IW-1:0] ULTIMO    = IW'(DIGITOS - 1);
    localparam logic [EW-1:0] ERR_MAX   = EW'(MAX_ERROS);
    localparam logic [EW-1:0] ERR_BLOQ  = EW'(MAX_ERROS + 1);
    localparam logic [TW-1:0] TIMER_INI = TW'(BLOQUEIO_CICLOS - 1);

    typedef enum logic [1:0] {
        ENTRADA  = 2'd0,
        ABERTO   = 2'd1,
        BLOQUEIO = 2'd2
    } estado_t;

    estado_t               estado, estado_n;
    logic [IW-1:0]         idx, idx_n;
    logic [EW-1:0]         erros_q, erros_n;
    logic [TW-1:0]         timer, timer_n;
    logic [4*DIGITOS-1:0]  senha_q, senha_n;
    logic [3:0]            digito, digito_n;
    logic                  insere_q;
    logic                  aceita;
    logic [4*DIGITOS-1:0]  senha_sh;
    logic [3:0]            nibble;
    logic [6:0]            seg;

    // Rising edge of insere; insere_q resets high so a level held through reset is not a digit.
    assign aceita   = insere & ~insere_q;
    // Expected digit: shift the code so nibble idx lands in the top position (MS nibble first).
    assign senha_sh = senha_q << {idx, 2'b00};
    assign nibble   = senha_sh[4*DIGITOS-1 -: 4];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= ENTRADA;
        else        estado <= estado_n;
    end

    // Datapath registers: edge detector, digit index, error count, lockout timer, code, display digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            insere_q <= 1'b1;
            idx      <= '0;
            erros_q  <= '0;
            timer    <= '0;
            senha_q  <= SENHA;
            digito   <= 4'h0;
        end else begin
            insere_q <= insere;
            idx      <= idx_n;
            erros_q  <= erros_n;
            timer    <= timer_n;
            senha_q  <= senha_n;
            digito   <= digito_n;
        end
    end

    // Next-state and datapath update for each state.
    always_comb begin
        estado_n = estado;
        idx_n    = idx;
        erros_n  = erros_q;
        timer_n  = timer;
        senha_n  = senha_q;
        digito_n = digito;
        case (estado)
            ENTRADA: begin
                if (aceita) begin
                    digito_n = numero;
                    if (numero == nibble) begin
                        if (idx == ULTIMO) begin
                            estado_n = ABERTO;
                            idx_n    = '0;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else if (erros_q < ERR_MAX) begin
                        // Wrong digit within tolerance: retry the same position.
                        erros_n = erros_q + 1'b1;
                    end else begin
                        estado_n = BLOQUEIO;
                        erros_n  = ERR_BLOQ;
                        timer_n  = TIMER_INI;
                    end
                end
            end
            ABERTO: begin
                // A code load and an F digit in the same cycle both take effect.
                if (grava) senha_n = nova_senha;
                if (aceita) begin
                    digito_n = numero;
                    if (numero == 4'hF) begin
                        estado_n = ENTRADA;
                        idx_n    = '0;
                        erros_n  = '0;
                    end
                end
            end
            BLOQUEIO: begin
                if (timer == '0) begin
                    estado_n = ENTRADA;
                    idx_n    = '0;
                    erros_n  = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                estado_n = ENTRADA;
                idx_n    = '0;
                erros_n  = '0;
            end
        endcase
    end

    // Output decode from registered state: status flags and seven-segment glyph {A..G}.
    always_comb begin
        aberto    = (estado == ABERTO);
        bloqueado = (estado == BLOQUEIO);
        LED       = (erros_q != '0);
        erros     = erros_q;
        seg       = 7'b1111110;
        case (estado)
            ABERTO:   seg = 7'b1110111;
            BLOQUEIO: seg = 7'b1001111;
            default: begin
                case (digito)
                    4'h0: seg = 7'b1111110;
                    4'h1: seg = 7'b0110000;
                    4'h2: seg = 7'b1101101;
                    4'h3: seg = 7'b1111001;
                    4'h4: seg = 7'b0110011;
                    4'h5: seg = 7'b1011011;
                    4'h6: seg = 7'b1011111;
                    4'h7: seg = 7'b1110000;
                    4'h8: seg = 7'b1111111;
                    4'h9: seg = 7'b1111011;
                    4'hA: seg = 7'b1110111;
                    4'hB: seg = 7'b0011111;
                    4'hC: seg = 7'b1001110;
                    4'hD: seg = 7'b0111101;
                    4'hE: seg = 7'b1001111;
                    default: seg = 7'b1000111;
                endcase
            end
        endcase
        {A, B, C, D, E, F, G} = seg;
    end

endmodule

// File: tb/tb_maquina_senha.sv
`timescale 1ns/1ps
// Bench for maquina_senha with default parameters: directed digit sequences,
// expected outputs queued by the driver and compared by a separate monitor.
module tb_maquina_senha;

    logic        clk = 1'b0;
    logic        reset;
    logic        insere;
    logic [3:0]  numero;
    logic        grava;
    logic [23:0] nova_senha;
    logic        LED, aberto, bloqueado;
    logic [1:0]  erros;
    logic        A, B, C, D, E, F, G;

    maquina_senha dut (
        .clk        (clk),
        .reset      (reset),
        .insere     (insere),
        .numero     (numero),
        .grava      (grava),
        .nova_senha (nova_senha),
        .LED        (LED),
        .aberto     (aberto),
        .bloqueado  (bloqueado),
        .erros      (erros),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
    );

    always #5 clk = ~clk;

    // Hand-written hex glyphs {A..G}
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    localparam logic [6:0] S_RST = 7'b1111110;
    localparam logic [6:0] S_A   = 7'b1110111;
    localparam logic [6:0] S_E   = 7'b1001111;

    typedef struct {
        int         id;
        logic       ab;
        logic       bl;
        logic       led;
        logic [1:0] er;
        logic [6:0] seg;
        logic       care;
    } exp_t;

    exp_t sb[$];
    event chk_now;
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    // Monitor: drains the scoreboard whenever the driver signals that outputs are settled.
    initial begin
        exp_t       e;
        logic [6:0] got_seg;
        forever begin
            @(chk_now);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got_seg = {A, B, C, D, E, F, G};
                checks++;
                if (aberto !== e.ab || bloqueado !== e.bl || LED !== e.led || erros !== e.er ||
                    (e.care && got_seg !== e.seg)) begin
                    errors++;
                    $display("FAIL step%0d: got aberto=%b bloq=%b LED=%b erros=%0d seg=%b, want aberto=%b bloq=%b LED=%b erros=%0d seg=%b%s",
                             e.id, aberto, bloqueado, LED, erros, got_seg,
                             e.ab, e.bl, e.led, e.er, e.seg, e.care ? "" : "(ignored)");
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic expect_out(input logic ab, input logic bl, input logic led,
                              input logic [1:0] er, input logic [6:0] seg, input logic care);
        exp_t e;
        step++;
        e.id = step; e.ab = ab; e.bl = bl; e.led = led; e.er = er; e.seg = seg; e.care = care;
        sb.push_back(e);
        -> chk_now;
    endtask

    // One insere pulse: accepted at a posedge, checked 2ns later, then insere dropped for a cycle.
    task automatic pulse(input logic [3:0] d, input logic ab, input logic bl, input logic led,
                         input logic [1:0] er, input logic [6:0] seg, input logic care);
        @(negedge clk); insere = 1'b1; numero = d;
        @(posedge clk); #2;
        expect_out(ab, bl, led, er, seg, care);
        @(negedge clk); insere = 1'b0;
        @(posedge clk);
    endtask

    // Enter a full 6-digit code with no mistakes; LED/erros stay at the given values.
    task automatic enter_code(input logic [23:0] code, input logic led, input logic [1:0] er);
        logic [3:0] d;
        for (int k = 0; k < 6; k++) begin
            d = code[23-4*k -: 4];
            if (k < 5) pulse(d, 1'b0, 1'b0, led, er, SEG_TAB[d], 1'b1);
            else       pulse(d, 1'b1, 1'b0, led, er, S_A, 1'b1);
        end
    endtask

    task automatic reset_now();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        expect_out(1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b1);
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; insere = 1'b1; numero = 4'h0; grava = 1'b0; nova_senha = 24'h0;
        #12;
        expect_out(1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b1);
        // insere held high across reset release must not count as a digit
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        expect_out(1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b1);
        @(negedge clk); insere = 1'b0;

        // grava outside ABERTO is ignored
        @(negedge clk); grava = 1'b1; nova_senha = 24'h123456;
        @(negedge clk); grava = 1'b0;

        // Correct default code opens; F returns to entry
        enter_code(24'h590981, 1'b0, 2'd0);
        pulse(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b0);

        // One wrong digit tolerated, LED stays on through open
        pulse(4'h5, 1'b0, 1'b0, 1'b0, 2'd0, SEG_TAB[5], 1'b1);
        pulse(4'h3, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[3], 1'b1);
        pulse(4'h9, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[9], 1'b1);
        pulse(4'h0, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[0], 1'b1);
        pulse(4'h9, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[9], 1'b1);
        pulse(4'h8, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[8], 1'b1);
        pulse(4'h1, 1'b1, 1'b0, 1'b1, 2'd1, S_A, 1'b1);
        pulse(4'h7, 1'b1, 1'b0, 1'b1, 2'd1, S_A, 1'b1);
        pulse(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b0);

        // Second error locks out; lockout lasts 16 edges after the entering edge
        pulse(4'h5, 1'b0, 1'b0, 1'b0, 2'd0, SEG_TAB[5], 1'b1);
        pulse(4'h3, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[3], 1'b1);
        pulse(4'h4, 1'b0, 1'b1, 1'b1, 2'd2, S_E, 1'b1);
        for (int k = 0; k < 5; k++)
            pulse(4'h5, 1'b0, 1'b1, 1'b1, 2'd2, S_E, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        expect_out(1'b0, 1'b1, 1'b1, 2'd2, S_E, 1'b1);
        @(posedge clk); #2;
        expect_out(1'b0, 1'b0, 1'b0, 2'd0, SEG_TAB[4], 1'b1);

        // Load a new code while open, then leave with F
        enter_code(24'h590981, 1'b0, 2'd0);
        @(negedge clk); grava = 1'b1; nova_senha = 24'h123456;
        @(posedge clk); #2;
        expect_out(1'b1, 1'b0, 1'b0, 2'd0, S_A, 1'b1);
        @(negedge clk); grava = 1'b0;
        pulse(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b0);
        enter_code(24'h123456, 1'b0, 2'd0);
        pulse(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b0);
        pulse(4'h5, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[5], 1'b1);
        enter_code(24'h123456, 1'b1, 2'd1);

        // grava together with F: code restored and FSM leaves ABERTO
        @(negedge clk); insere = 1'b1; numero = 4'hF; grava = 1'b1; nova_senha = 24'h590981;
        @(posedge clk); #2;
        expect_out(1'b0, 1'b0, 1'b0, 2'd0, S_RST, 1'b0);
        @(negedge clk); insere = 1'b0; grava = 1'b0;
        @(posedge clk);

        // insere held for 5 cycles gives a single digit; next digit continues at index 1
        @(negedge clk); insere = 1'b1; numero = 4'h5;
        repeat (5) @(posedge clk);
        #2;
        expect_out(1'b0, 1'b0, 1'b0, 2'd0, SEG_TAB[5], 1'b1);
        @(negedge clk); insere = 1'b0;
        @(posedge clk);
        pulse(4'h9, 1'b0, 1'b0, 1'b0, 2'd0, SEG_TAB[9], 1'b1);
        pulse(4'h3, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[3], 1'b1);
        reset_now();

        // Reset during lockout clears it; default code then opens
        pulse(4'h5, 1'b0, 1'b0, 1'b0, 2'd0, SEG_TAB[5], 1'b1);
        pulse(4'h3, 1'b0, 1'b0, 1'b1, 2'd1, SEG_TAB[3], 1'b1);
        pulse(4'h4, 1'b0, 1'b1, 1'b1, 2'd2, S_E, 1'b1);
        repeat (3) @(posedge clk);
        reset_now();
        enter_code(24'h590981, 1'b0, 2'd0);

        // Reset in ABERTO after loading a code discards the loaded code
        @(negedge clk); grava = 1'b1; nova_senha = 24'h123456;
        @(negedge clk); grava = 1'b0;
        reset_now();
        enter_code(24'h590981, 1'b0, 2'd0);

        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
